sa_matmul_os: RTL and testbench

- Parametrised output-stationary matmul engine: C[NUM_ROWS][NUM_COLS] = A[NUM_ROWS][K] x B[K][NUM_COLS], K programmable per job up to MAX_K.
- Streams one A column and one B row per accepted beat, skews them internally, accumulates in a PE grid, then drains C one row per beat.
- Successor to the fixed 8-row memory-sequenced matmul top.
- Adds runtime K, valid/ready streaming with bubbles, cross-job accumulation and drain back-pressure.

---
 rtl/sa_matmul_os.sv | 278 +++++++++++++++++++++++++++
 tb/tb_sa_matmul_os.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_matmul_os.sv
`default_nettype none
// ============================================================================
//  Module   : sa_matmul_os
//  Purpose  : Output-stationary systolic matrix multiplier.
//             C[NUM_ROWS][NUM_COLS] = A[NUM_ROWS][K] x B[K][NUM_COLS] with K
//             programmable per job (clamped to MAX_K). One A column and one
//             B row are accepted per beat, skewed into a PE grid, accumulated
//             in place, then drained one C row per beat.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n       clock, asynchronous active-low reset
//    i_start          job start (IDLE only); samples i_k and i_acc
//    i_k              reduction length (values above MAX_K are clamped)
//    i_acc            1 = continue accumulating, 0 = clear accumulators
//    o_busy           high while a job is in progress
//    o_done           one-cycle pulse after the last drain beat
//    i_in_valid       operand beat valid
//    o_in_ready       operand beat accepted (high during LOAD)
//    i_a              A column, element r at [r*MUL_DATAWIDTH +: MUL_DATAWIDTH]
//    i_b              B row, element c at [c*MUL_DATAWIDTH +: MUL_DATAWIDTH]
//    o_out_valid      C row valid (high during DRAIN)
//    i_out_ready      C row consumed on o_out_valid & i_out_ready
//    o_out_data       C row, element c at [c*ADD_DATAWIDTH +: ADD_DATAWIDTH]
//    o_out_row        row index of o_out_data
// ============================================================================
module sa_matmul_os #(
  parameter int MUL_DATAWIDTH = 8,
  parameter int ADD_DATAWIDTH = 32,
  parameter int NUM_ROWS      = 4,
  parameter int NUM_COLS      = 4,
  parameter int MAX_K         = 256,
  parameter int KW            = $clog2(MAX_K + 1),
  parameter int RW            = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic [KW-1:0]                     i_k,
  input  logic                              i_acc,
  output logic                              o_busy,
  output logic                              o_done,
  input  logic                              i_in_valid,
  output logic                              o_in_ready,
  input  logic [MUL_DATAWIDTH*NUM_ROWS-1:0] i_a,
  input  logic [MUL_DATAWIDTH*NUM_COLS-1:0] i_b,
  output logic                              o_out_valid,
  input  logic                              i_out_ready,
  output logic [ADD_DATAWIDTH*NUM_COLS-1:0] o_out_data,
  output logic [RW-1:0]                     o_out_row
);

  localparam int MW      = MUL_DATAWIDTH;
  localparam int AW      = ADD_DATAWIDTH;
  localparam int PW      = 2 * MUL_DATAWIDTH;
  localparam int FLUSH_N = NUM_ROWS + NUM_COLS - 1;
  localparam int FW      = $clog2(FLUSH_N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            clr_acc;
  logic [KW-1:0]   k_clamped;
  logic            in_fire;
  logic            out_fire;

  assign k_clamped = (i_k > KW'(MAX_K)) ? KW'(MAX_K) : i_k;
  assign in_fire   = i_in_valid & (state_q == S_LOAD);
  assign out_fire  = i_out_ready & (state_q == S_DRAIN);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clr_acc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          k_d     = k_clamped;
          cnt_d   = '0;
          flush_d = '0;
          row_d   = '0;
          clr_acc = ~i_acc;
          state_d = (k_clamped != '0) ? S_LOAD : S_FLUSH;
        end
      end
      S_LOAD: begin
        if (in_fire) begin
          cnt_d = cnt_q + KW'(1);
          if (cnt_q + KW'(1) == k_q) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Long enough for the last beat to cross the full skew + grid diagonal.
        if (flush_q == FW'(FLUSH_N - 1)) begin
          state_d = S_DRAIN;
        end else begin
          flush_d = flush_q + FW'(1);
        end
      end
      S_DRAIN: begin
        if (out_fire) begin
          if (row_q == RW'(NUM_ROWS - 1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_in_ready  = (state_q == S_LOAD);
  assign o_out_valid = (state_q == S_DRAIN);
  assign o_out_row   = row_q;
  assign o_done      = done_q;

  // --------------------------------------------------------------------------
  // PE input networks. Column 0 / row 0 are fed from the skew lines; every
  // other entry is fed by the forwarding registers of the neighbouring PE.
  // --------------------------------------------------------------------------
  logic [MW-1:0] a_pe_in  [NUM_ROWS][NUM_COLS];
  logic          av_pe_in [NUM_ROWS][NUM_COLS];
  logic [MW-1:0] b_pe_in  [NUM_ROWS][NUM_COLS];
  logic          bv_pe_in [NUM_ROWS][NUM_COLS];
  logic [AW-1:0] acc_out  [NUM_ROWS][NUM_COLS];

  // A element r is delayed r cycles before entering the grid.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_askew
    if (r == 0) begin : g_direct
      assign a_pe_in[0][0]  = i_a[MW-1:0];
      assign av_pe_in[0][0] = in_fire;
    end else begin : g_delay
      logic [MW-1:0] d_q [r];
      logic [r-1:0]  v_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) d_q[i] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= i_a[r*MW +: MW];
          v_q[0] <= in_fire;
          for (int i = 1; i < r; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign a_pe_in[r][0]  = d_q[r-1];
      assign av_pe_in[r][0] = v_q[r-1];
    end
  end

  // B element c is delayed c cycles before entering the grid.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_bskew
    if (c == 0) begin : g_direct
      assign b_pe_in[0][0]  = i_b[MW-1:0];
      assign bv_pe_in[0][0] = in_fire;
    end else begin : g_delay
      logic [MW-1:0] d_q [c];
      logic [c-1:0]  v_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) d_q[i] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= i_b[c*MW +: MW];
          v_q[0] <= in_fire;
          for (int i = 1; i < c; i++) begin
            d_q[i] <= d_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end
      assign b_pe_in[0][c]  = d_q[c-1];
      assign bv_pe_in[0][c] = v_q[c-1];
    end
  end

  // --------------------------------------------------------------------------
  // PE grid. Each PE registers its operands; the registered pair is both
  // multiplied locally and forwarded right (a) and down (b).
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_pe_col
      logic signed [MW-1:0] a_q, b_q;
      logic                 av_q, bv_q;
      logic signed [AW-1:0] acc_q;
      logic signed [PW-1:0] prod;

      assign prod = a_q * b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          av_q  <= 1'b0;
          bv_q  <= 1'b0;
          acc_q <= '0;
        end else begin
          a_q  <= a_pe_in[r][c];
          b_q  <= b_pe_in[r][c];
          av_q <= av_pe_in[r][c];
          bv_q <= bv_pe_in[r][c];
          if (clr_acc) begin
            acc_q <= '0;
          end else if (av_q && bv_q) begin
            // Signed cast sign-extends the full product; sum wraps.
            acc_q <= acc_q + AW'(prod);
          end
        end
      end

      assign acc_out[r][c] = acc_q;

      if (c < NUM_COLS - 1) begin : g_fwd_a
        assign a_pe_in[r][c+1]  = a_q;
        assign av_pe_in[r][c+1] = av_q;
      end
      if (r < NUM_ROWS - 1) begin : g_fwd_b
        assign b_pe_in[r+1][c]  = b_q;
        assign bv_pe_in[r+1][c] = bv_q;
      end
    end
  end

  // Row mux; output is forced to zero outside DRAIN.
  always_comb begin
    o_out_data = '0;
    if (state_q == S_DRAIN) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        o_out_data[c*AW +: AW] = acc_out[row_q][c];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_matmul_os.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa_matmul_os
//  Purpose  : Directed self-checking bench for sa_matmul_os. Two instances
//             share one stimulus: a 32-bit accumulator build and a 16-bit one
//             that exposes modular wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sa_matmul_os;

  localparam int R    = 4;
  localparam int C    = 4;
  localparam int MW   = 8;
  localparam int MAXK = 8;
  localparam int KW   = 4;
  localparam int RW   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_start, i_acc, i_in_valid, i_out_ready;
  logic [KW-1:0]   i_k;
  logic [MW*R-1:0] i_a;
  logic [MW*C-1:0] i_b;

  logic            o_busy, o_done, o_in_ready, o_out_valid;
  logic [32*C-1:0] o_out_data;
  logic [RW-1:0]   o_out_row;

  logic            w_busy, w_done, w_in_ready, w_out_valid;
  logic [16*C-1:0] w_out_data;
  logic [RW-1:0]   w_out_row;

  always #5 clk = ~clk;

  sa_matmul_os #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(32), .NUM_ROWS(R),
                 .NUM_COLS(C), .MAX_K(MAXK)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k(i_k), .i_acc(i_acc),
    .o_busy(o_busy), .o_done(o_done), .i_in_valid(i_in_valid),
    .o_in_ready(o_in_ready), .i_a(i_a), .i_b(i_b), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_data(o_out_data), .o_out_row(o_out_row));

  sa_matmul_os #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(16), .NUM_ROWS(R),
                 .NUM_COLS(C), .MAX_K(MAXK)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k(i_k), .i_acc(i_acc),
    .o_busy(w_busy), .o_done(w_done), .i_in_valid(i_in_valid),
    .o_in_ready(w_in_ready), .i_a(i_a), .i_b(i_b), .o_out_valid(w_out_valid),
    .i_out_ready(i_out_ready), .o_out_data(w_out_data), .o_out_row(w_out_row));

  int checks   = 0;
  int failures = 0;

  int          A_mat [R][MAXK];
  int          B_mat [MAXK][C];
  longint      exp_c [R][C];
  logic [31:0] obs32 [R][C];
  logic [15:0] obs16 [R][C];
  logic [RW-1:0] obs_row [R];
  int          lat, unstable, busy_low, done_cnt;
  logic        done_at, busy_at, done_next, busy_next, ready_after;
  bit          ready_all;

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill(input int av, input int bv);
    for (int r = 0; r < R; r++) for (int k = 0; k < MAXK; k++) A_mat[r][k] = av;
    for (int k = 0; k < MAXK; k++) for (int c = 0; c < C; c++) B_mat[k][c] = bv;
  endtask

  task automatic set_exp(input longint v);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_c[r][c] = v;
  endtask

  task automatic start_job(input int k, input bit acc);
    i_start = 1'b1; i_k = k[KW-1:0]; i_acc = acc;
    tick();
    i_start = 1'b0;
  endtask

  task automatic drive_beat(input int kk);
    for (int r = 0; r < R; r++) i_a[r*MW +: MW] = A_mat[r][kk][MW-1:0];
    for (int c = 0; c < C; c++) i_b[c*MW +: MW] = B_mat[kk][c][MW-1:0];
    i_in_valid = 1'b1;
  endtask

  task automatic run_load(input int k, input bit bubble);
    ready_all = 1'b1;
    for (int kk = 0; kk < k; kk++) begin
      if (bubble && kk > 0) begin
        i_in_valid = 1'b0;
        if (o_in_ready !== 1'b1) ready_all = 1'b0;
        tick();
      end
      drive_beat(kk);
      if (o_in_ready !== 1'b1) ready_all = 1'b0;
      tick();
    end
    i_in_valid  = 1'b0;
    ready_after = o_in_ready;
  endtask

  // Waits for DRAIN, records every row, optionally stalls and pulses i_start.
  task automatic drain_collect(input int stall, input bit pulse);
    logic [32*C-1:0] d0;
    lat = 0; unstable = 0; busy_low = 0;
    while (o_out_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
    if (lat >= 60) return;
    for (int r = 0; r < R; r++) begin
      obs_row[r] = o_out_row;
      d0 = o_out_data;
      for (int c = 0; c < C; c++) begin
        obs32[r][c] = o_out_data[c*32 +: 32];
        obs16[r][c] = w_out_data[c*16 +: 16];
      end
      for (int s = 0; s < stall; s++) begin
        if (pulse && r == 1 && s == 0) begin
          i_start = 1'b1; i_k = 4'd1; i_acc = 1'b0;
        end
        tick();
        i_start = 1'b0;
        if (o_out_valid !== 1'b1 || o_out_row !== obs_row[r] || o_out_data !== d0)
          unstable++;
        if (o_busy !== 1'b1) busy_low++;
      end
      i_out_ready = 1'b1;
      tick();
      i_out_ready = 1'b0;
    end
    done_at = o_done; busy_at = o_busy;
    tick();
    done_next = o_done; busy_next = o_busy;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0; i_start = 0; i_k = 0; i_acc = 0; i_in_valid = 0;
    i_a = '0; i_b = '0; i_out_ready = 0; done_cnt = 0;
    tick(); tick();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", o_done); end
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", o_in_ready); end
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", o_out_valid); end
    checks++; if (o_out_row !== '0) begin failures++; $display("FAIL reset_out_row got=%0d exp=0", o_out_row); end
    checks++; if (o_out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", o_out_data); end
    checks++; if (w_out_data !== '0) begin failures++; $display("FAIL reset_out_data16 got=%h exp=0", w_out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_identity();
    for (int r = 0; r < R; r++) for (int k = 0; k < MAXK; k++) A_mat[r][k] = (r == k) ? 1 : 0;
    for (int k = 0; k < MAXK; k++) for (int c = 0; c < C; c++) B_mat[k][c] = 4*k + c + 1;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_c[r][c] = 4*r + c + 1;
    start_job(4, 1'b0);
    run_load(4, 1'b0);
    drain_collect(0, 1'b0);
    checks++; if (ready_all !== 1'b1) begin failures++; $display("FAIL ident_ready got=%b exp=1", ready_all); end
    checks++; if (ready_after !== 1'b0) begin failures++; $display("FAIL ident_ready_after got=%b exp=0", ready_after); end
    checks++; if (lat != 7) begin failures++; $display("FAIL ident_latency got=%0d exp=7", lat); end
    for (int r = 0; r < R; r++) begin
      checks++; if (obs_row[r] !== r[RW-1:0]) begin failures++; $display("FAIL ident_row got=%0d exp=%0d", obs_row[r], r); end
      for (int c = 0; c < C; c++) begin
        checks++;
        if (obs32[r][c] !== exp_c[r][c][31:0]) begin
          failures++; $display("FAIL ident_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
        end
      end
    end
    checks++; if (done_at !== 1'b1) begin failures++; $display("FAIL ident_done got=%b exp=1", done_at); end
    checks++; if (busy_at !== 1'b0) begin failures++; $display("FAIL ident_busy_after got=%b exp=0", busy_at); end
    checks++; if (done_next !== 1'b0) begin failures++; $display("FAIL ident_done_pulse got=%b exp=0", done_next); end
  endtask

  task automatic test_bubbles();
    fill(1, 1); set_exp(3);
    start_job(3, 1'b0);
    run_load(3, 1'b1);
    checks++; if (ready_all !== 1'b1) begin failures++; $display("FAIL bubble_ready got=%b exp=1", ready_all); end
    checks++; if (ready_after !== 1'b0) begin failures++; $display("FAIL bubble_ready_drop got=%b exp=0", ready_after); end
    drain_collect(0, 1'b0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== exp_c[r][c][31:0]) begin
        failures++; $display("FAIL bubble_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
      end
    end
  endtask

  task automatic test_accumulate();
    fill(1, 1); set_exp(6);
    start_job(3, 1'b1);
    run_load(3, 1'b1);
    drain_collect(0, 1'b0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== exp_c[r][c][31:0]) begin
        failures++; $display("FAIL acc_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
      end
    end
    start_job(0, 1'b1);
    drain_collect(0, 1'b0);
    checks++; if (lat != 7) begin failures++; $display("FAIL acc_k0_latency got=%0d exp=7", lat); end
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== exp_c[r][c][31:0]) begin
        failures++; $display("FAIL acc_k0_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
      end
    end
    fill(2, 2); set_exp(4);
    start_job(1, 1'b0);
    run_load(1, 1'b0);
    drain_collect(0, 1'b0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== exp_c[r][c][31:0]) begin
        failures++; $display("FAIL acc_clear_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
      end
    end
  endtask

  task automatic test_signed_wrap();
    // 3 x (-128 * -128) = 49152; 16-bit accumulator wraps to 0xC000 (-16384).
    fill(-128, -128); set_exp(49152);
    start_job(3, 1'b0);
    run_load(3, 1'b0);
    drain_collect(0, 1'b0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== exp_c[r][c][31:0]) begin
        failures++; $display("FAIL signed32_c[%0d][%0d] got=%h exp=%h", r, c, obs32[r][c], exp_c[r][c][31:0]);
      end
      checks++;
      if (obs16[r][c] !== 16'hC000) begin
        failures++; $display("FAIL wrap16_c[%0d][%0d] got=%h exp=c000", r, c, obs16[r][c]);
      end
    end
    // -128 * 127 = -16256 = 0xFFFFC080 / 0xC080.
    fill(-128, 127); set_exp(-16256);
    start_job(1, 1'b0);
    run_load(1, 1'b0);
    drain_collect(0, 1'b0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== 32'hFFFF_C080) begin
        failures++; $display("FAIL neg32_c[%0d][%0d] got=%h exp=ffffc080", r, c, obs32[r][c]);
      end
      checks++;
      if (obs16[r][c] !== 16'hC080) begin
        failures++; $display("FAIL neg16_c[%0d][%0d] got=%h exp=c080", r, c, obs16[r][c]);
      end
    end
  endtask

  task automatic test_backpressure();
    // A[r][k] = r+1, B[k][c] = c+1, K=2  ->  C[r][c] = 2*(r+1)*(c+1)
    for (int r = 0; r < R; r++) for (int k = 0; k < MAXK; k++) A_mat[r][k] = r + 1;
    for (int k = 0; k < MAXK; k++) for (int c = 0; c < C; c++) B_mat[k][c] = c + 1;
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) exp_c[r][c] = 2*(r+1)*(c+1);
    start_job(2, 1'b0);
    run_load(2, 1'b0);
    drain_collect(5, 1'b1);
    checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
    checks++; if (busy_low != 0) begin failures++; $display("FAIL bp_busy_during_drain got=%0d exp=0", busy_low); end
    for (int r = 0; r < R; r++) begin
      checks++; if (obs_row[r] !== r[RW-1:0]) begin failures++; $display("FAIL bp_row got=%0d exp=%0d", obs_row[r], r); end
      for (int c = 0; c < C; c++) begin
        checks++;
        if (obs32[r][c] !== exp_c[r][c][31:0]) begin
          failures++; $display("FAIL bp_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
        end
      end
    end
    checks++; if (done_at !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done_at); end
    checks++; if (busy_next !== 1'b0) begin failures++; $display("FAIL bp_no_restart got=%b exp=0", busy_next); end
  endtask

  task automatic test_clamp();
    int beats;
    fill(1, 1); set_exp(8);
    start_job(15, 1'b0);
    beats = 0;
    for (int n = 0; n < 20; n++) begin
      if (o_in_ready !== 1'b1) break;
      drive_beat(0);
      tick();
      beats++;
    end
    i_in_valid = 1'b0;
    checks++; if (beats != MAXK) begin failures++; $display("FAIL clamp_beats got=%0d exp=%0d", beats, MAXK); end
    drain_collect(0, 1'b0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== exp_c[r][c][31:0]) begin
        failures++; $display("FAIL clamp_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
      end
    end
  endtask

  task automatic test_reset_midload();
    int dc;
    fill(1, 1);
    start_job(4, 1'b0);
    drive_beat(0); tick();
    drive_beat(1); tick();
    dc = done_cnt;
    rst_n = 1'b0;
    #2;
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    checks++; if (o_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", o_in_ready); end
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", o_out_valid); end
    checks++; if (o_out_row !== '0) begin failures++; $display("FAIL rst_out_row got=%0d exp=0", o_out_row); end
    checks++; if (o_out_data !== '0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", o_out_data); end
    checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", o_done); end
    i_in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) tick();
    checks++; if (done_cnt != dc) begin failures++; $display("FAIL rst_no_done got=%0d exp=%0d", done_cnt, dc); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b exp=0", o_busy); end
    fill(3, 5); set_exp(15);
    start_job(1, 1'b1);
    run_load(1, 1'b0);
    drain_collect(0, 1'b0);
    for (int r = 0; r < R; r++) for (int c = 0; c < C; c++) begin
      checks++;
      if (obs32[r][c] !== exp_c[r][c][31:0]) begin
        failures++; $display("FAIL rst_acc_c[%0d][%0d] got=%0d exp=%0d", r, c, obs32[r][c], exp_c[r][c]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_bubbles();
    test_accumulate();
    test_signed_wrap();
    test_backpressure();
    test_clamp();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
